mouse_pkt: RTL and testbench

MOUSE_PKT -- requirements
Module: mouse_pkt

---
 rtl/mouse_pkt_pkg.sv | 30 +++
 rtl/mouse_pkt_if.sv | 9 +
 rtl/mouse_pkt.sv | 132 +++++++++++++
 tb/tb_mouse_pkt.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mouse_pkt_pkg.sv
// Shared types and status-byte bit positions for the PS/2 mouse packet assembler.
package mouse_pkt_pkg;

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2
  } state_t;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;
  localparam int SYNC  = 3;
  localparam int XS    = 4;
  localparam int YS    = 5;
  localparam int XO    = 6;
  localparam int YO    = 7;

  // Overflowed deltas saturate to the extreme of their sign: +255 -> FF, -256 -> 00.
  function automatic logic [7:0] ovf_fix(input logic [7:0] val, input logic ovf, input logic sign);
    logic [7:0] res;
    if (ovf) begin
      res = sign ? 8'h00 : 8'hFF;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/mouse_pkt_if.sv
// Received-byte strobe bus from the PS/2 receiver into the packet assembler.
interface mouse_pkt_if;
  logic       PS2_VALID;
  logic [7:0] PS2_DATA;
  logic       PS2_ERR;

  modport master (output PS2_VALID, output PS2_DATA, output PS2_ERR);
  modport slave  (input  PS2_VALID, input  PS2_DATA, input  PS2_ERR);
endinterface

// File: rtl/mouse_pkt.sv
// Assembles three PS/2 mouse bytes into one packet word with a toggle strobe,
// discarding bytes on sync loss, receive errors, inter-byte timeout or disable.
module mouse_pkt
  import mouse_pkt_pkg::*;
#(
  parameter int TIMEOUT = 2047
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         CE,
  input  logic         ENABLE,
  mouse_pkt_if.slave   ps2,
  output logic [24:0]  MOUSE,
  output logic         PKT_ERR
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  state_t        state_r;
  state_t        state_nxt_s;
  state_t        eff_state_s;
  logic [TW-1:0] gap_r;
  logic [TW-1:0] gap_nxt_s;
  logic [7:0]    status_r;
  logic [7:0]    dx_r;
  logic [24:0]   mouse_r;
  logic          pkt_err_r;
  logic          timeout_s;
  logic          err_s;
  logic          commit_s;
  logic          take_status_s;
  logic          take_dx_s;
  logic          accept_s;
  logic [24:0]   commit_val_s;

  assign timeout_s = (state_r != WAIT_B0) && (gap_r == TMAX);

  // dy comes straight off the bus on the commit edge, so it is never stored.
  assign commit_val_s = {~mouse_r[24],
                         ovf_fix(ps2.PS2_DATA, status_r[YO], status_r[YS]),
                         ovf_fix(dx_r, status_r[XO], status_r[XS]),
                         status_r};

  // Next-state and byte-handling decisions; a timeout rewinds to WAIT_B0 before the byte is judged.
  always_comb begin
    state_nxt_s   = state_r;
    eff_state_s   = state_r;
    err_s         = 1'b0;
    commit_s      = 1'b0;
    take_status_s = 1'b0;
    take_dx_s     = 1'b0;
    accept_s      = 1'b0;
    if (!ENABLE) begin
      state_nxt_s = WAIT_B0;
    end else begin
      if (timeout_s) begin
        eff_state_s = WAIT_B0;
        err_s       = 1'b1;
      end else begin
        eff_state_s = state_r;
      end
      if (ps2.PS2_VALID && ps2.PS2_ERR) begin
        state_nxt_s = WAIT_B0;
        err_s       = 1'b1;
      end else if (ps2.PS2_VALID) begin
        case (eff_state_s)
          WAIT_B0: begin
            if (ps2.PS2_DATA[SYNC]) begin
              take_status_s = 1'b1;
              accept_s      = 1'b1;
              state_nxt_s   = WAIT_B1;
            end else begin
              err_s         = 1'b1;
              state_nxt_s   = WAIT_B0;
            end
          end
          WAIT_B1: begin
            take_dx_s   = 1'b1;
            accept_s    = 1'b1;
            state_nxt_s = WAIT_B2;
          end
          WAIT_B2: begin
            commit_s    = 1'b1;
            accept_s    = 1'b1;
            state_nxt_s = WAIT_B0;
          end
          default: begin
            state_nxt_s = WAIT_B0;
          end
        endcase
      end else begin
        state_nxt_s = eff_state_s;
      end
    end
  end

  // Gap timer only runs mid-packet and saturates at TIMEOUT.
  always_comb begin
    gap_nxt_s = gap_r;
    if (!ENABLE || accept_s || (state_nxt_s == WAIT_B0)) begin
      gap_nxt_s = {TW{1'b0}};
    end else if (CE && (gap_r != TMAX)) begin
      gap_nxt_s = gap_r + TW'(1);
    end else begin
      gap_nxt_s = gap_r;
    end
  end

  // State, latched bytes and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_r   <= WAIT_B0;
      gap_r     <= {TW{1'b0}};
      status_r  <= 8'h00;
      dx_r      <= 8'h00;
      mouse_r   <= 25'd0;
      pkt_err_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      gap_r     <= gap_nxt_s;
      pkt_err_r <= err_s;
      if (take_status_s) status_r <= ps2.PS2_DATA;
      if (take_dx_s)     dx_r     <= ps2.PS2_DATA;
      if (commit_s)      mouse_r  <= commit_val_s;
    end
  end

  assign MOUSE   = mouse_r;
  assign PKT_ERR = pkt_err_r;

endmodule

// File: tb/tb_mouse_pkt.sv
// Directed bench for mouse_pkt: packet assembly, overflow clamping, resync, timeout and abort paths.
module tb_mouse_pkt;

  localparam int TO = 2047;

  logic        CLK;
  logic        RESET_N;
  logic        CE;
  logic        ENABLE;
  logic [24:0] MOUSE;
  logic        PKT_ERR;

  int   checks;
  int   fails;
  int   err_total;
  int   err_base;
  logic exp_tog;
  logic [24:0] exp_m;

  mouse_pkt_if ps2();

  mouse_pkt #(.TIMEOUT(TO)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .CE      (CE),
    .ENABLE  (ENABLE),
    .ps2     (ps2),
    .MOUSE   (MOUSE),
    .PKT_ERR (PKT_ERR)
  );

  always #5 CLK = ~CLK;

  // PKT_ERR pulses are counted between edges so each one is seen exactly once.
  always @(negedge CLK) begin
    if (PKT_ERR === 1'b1) err_total = err_total + 1;
  end

  task automatic put_byte(input logic [7:0] d, input logic e);
    ps2.PS2_VALID = 1'b1;
    ps2.PS2_DATA  = d;
    ps2.PS2_ERR   = e;
    @(posedge CLK);
    #1;
    ps2.PS2_VALID = 1'b0;
    ps2.PS2_ERR   = 1'b0;
  endtask

  task automatic idle(input int n);
    ps2.PS2_VALID = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RESET_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (MOUSE !== 25'd0) begin fails++; $display("FAIL reset_mouse: got %h expected %h", MOUSE, 25'd0); end
    checks++; if (PKT_ERR !== 1'b0) begin fails++; $display("FAIL reset_pkt_err: got %b expected 0", PKT_ERR); end
    RESET_N = 1'b1;
    exp_tog = 1'b0;
    idle(1);
  endtask

  task automatic test_back_to_back;
    err_base = err_total;
    put_byte(8'h08, 1'b0);
    put_byte(8'h05, 1'b0);
    checks++; if (MOUSE !== 25'd0) begin fails++; $display("FAIL b2b_no_early_commit: got %h expected %h", MOUSE, 25'd0); end
    put_byte(8'hFB, 1'b0);
    exp_tog = ~exp_tog; exp_m = {exp_tog, 24'hFB0508};
    checks++; if (MOUSE !== exp_m) begin fails++; $display("FAIL b2b_mouse: got %h expected %h", MOUSE, exp_m); end
    idle(1);
    checks++; if (err_total - err_base !== 0) begin fails++; $display("FAIL b2b_pkt_err: got %0d expected 0", err_total - err_base); end
  endtask

  task automatic test_resync;
    err_base = err_total;
    put_byte(8'h00, 1'b0);
    put_byte(8'h08, 1'b0);
    put_byte(8'h10, 1'b0);
    put_byte(8'h20, 1'b0);
    exp_tog = ~exp_tog; exp_m = {exp_tog, 24'h201008};
    checks++; if (MOUSE !== exp_m) begin fails++; $display("FAIL resync_mouse: got %h expected %h", MOUSE, exp_m); end
    idle(1);
    checks++; if (err_total - err_base !== 1) begin fails++; $display("FAIL resync_pkt_err: got %0d expected 1", err_total - err_base); end
  endtask

  task automatic test_overflow;
    put_byte(8'h58, 1'b0); put_byte(8'h12, 1'b0); put_byte(8'h34, 1'b0);
    exp_tog = ~exp_tog; exp_m = {exp_tog, 24'h340058};
    checks++; if (MOUSE !== exp_m) begin fails++; $display("FAIL xovf_neg: got %h expected %h", MOUSE, exp_m); end
    put_byte(8'h48, 1'b0); put_byte(8'h00, 1'b0); put_byte(8'h00, 1'b0);
    exp_tog = ~exp_tog; exp_m = {exp_tog, 24'h00FF48};
    checks++; if (MOUSE !== exp_m) begin fails++; $display("FAIL xovf_pos: got %h expected %h", MOUSE, exp_m); end
    put_byte(8'h88, 1'b0); put_byte(8'h11, 1'b0); put_byte(8'h22, 1'b0);
    exp_tog = ~exp_tog; exp_m = {exp_tog, 24'hFF1188};
    checks++; if (MOUSE !== exp_m) begin fails++; $display("FAIL yovf_pos: got %h expected %h", MOUSE, exp_m); end
    put_byte(8'hA8, 1'b0); put_byte(8'h11, 1'b0); put_byte(8'h22, 1'b0);
    exp_tog = ~exp_tog; exp_m = {exp_tog, 24'h0011A8};
    checks++; if (MOUSE !== exp_m) begin fails++; $display("FAIL yovf_neg: got %h expected %h", MOUSE, exp_m); end
  endtask

  task automatic test_timeout;
    err_base = err_total;
    put_byte(8'h09, 1'b0);
    put_byte(8'h01, 1'b0);
    idle(TO);
    // The next byte lands on the timeout cycle and must restart the packet.
    put_byte(8'h09, 1'b0);
    put_byte(8'h02, 1'b0);
    put_byte(8'h03, 1'b0);
    exp_tog = ~exp_tog; exp_m = {exp_tog, 24'h030209};
    checks++; if (MOUSE !== exp_m) begin fails++; $display("FAIL timeout_mouse: got %h expected %h", MOUSE, exp_m); end
    idle(1);
    checks++; if (err_total - err_base !== 1) begin fails++; $display("FAIL timeout_pkt_err: got %0d expected 1", err_total - err_base); end
  endtask

  task automatic test_no_timeout;
    err_base = err_total;
    put_byte(8'h09, 1'b0);
    put_byte(8'h01, 1'b0);
    idle(TO - 1);
    put_byte(8'h02, 1'b0);
    exp_tog = ~exp_tog; exp_m = {exp_tog, 24'h020109};
    checks++; if (MOUSE !== exp_m) begin fails++; $display("FAIL gap_below_limit_mouse: got %h expected %h", MOUSE, exp_m); end
    idle(1);
    checks++; if (err_total - err_base !== 0) begin fails++; $display("FAIL gap_below_limit_pkt_err: got %0d expected 0", err_total - err_base); end
  endtask

  task automatic test_ce_gate;
    err_base = err_total;
    CE = 1'b0;
    put_byte(8'h09, 1'b0);
    put_byte(8'h01, 1'b0);
    idle(TO + 10);
    put_byte(8'h03, 1'b0);
    CE = 1'b1;
    exp_tog = ~exp_tog; exp_m = {exp_tog, 24'h030109};
    checks++; if (MOUSE !== exp_m) begin fails++; $display("FAIL ce_gate_mouse: got %h expected %h", MOUSE, exp_m); end
    idle(1);
    checks++; if (err_total - err_base !== 0) begin fails++; $display("FAIL ce_gate_pkt_err: got %0d expected 0", err_total - err_base); end
  endtask

  task automatic test_ps2_err;
    err_base = err_total;
    put_byte(8'h08, 1'b0);
    put_byte(8'h01, 1'b0);
    put_byte(8'h02, 1'b1);
    idle(1);
    checks++; if (MOUSE !== exp_m) begin fails++; $display("FAIL ps2err_hold: got %h expected %h", MOUSE, exp_m); end
    checks++; if (err_total - err_base !== 1) begin fails++; $display("FAIL ps2err_pkt_err: got %0d expected 1", err_total - err_base); end
    put_byte(8'h08, 1'b0); put_byte(8'h07, 1'b0); put_byte(8'h07, 1'b0);
    exp_tog = ~exp_tog; exp_m = {exp_tog, 24'h070708};
    checks++; if (MOUSE !== exp_m) begin fails++; $display("FAIL ps2err_recover: got %h expected %h", MOUSE, exp_m); end
  endtask

  task automatic test_enable;
    err_base = err_total;
    put_byte(8'h08, 1'b0);
    put_byte(8'h01, 1'b0);
    ENABLE = 1'b0;
    put_byte(8'h00, 1'b0);
    ENABLE = 1'b1;
    idle(1);
    checks++; if (MOUSE !== exp_m) begin fails++; $display("FAIL enable_hold: got %h expected %h", MOUSE, exp_m); end
    checks++; if (err_total - err_base !== 0) begin fails++; $display("FAIL enable_pkt_err: got %0d expected 0", err_total - err_base); end
    put_byte(8'h08, 1'b0); put_byte(8'h02, 1'b0); put_byte(8'h03, 1'b0);
    exp_tog = ~exp_tog; exp_m = {exp_tog, 24'h030208};
    checks++; if (MOUSE !== exp_m) begin fails++; $display("FAIL enable_restart: got %h expected %h", MOUSE, exp_m); end
  endtask

  task automatic test_reset_mid;
    put_byte(8'h0A, 1'b0);
    RESET_N = 1'b0;
    idle(1);
    RESET_N = 1'b1;
    checks++; if (MOUSE !== 25'd0) begin fails++; $display("FAIL midreset_mouse: got %h expected %h", MOUSE, 25'd0); end
    exp_tog = 1'b0;
    put_byte(8'h0A, 1'b0); put_byte(8'h01, 1'b0); put_byte(8'h01, 1'b0);
    exp_tog = ~exp_tog; exp_m = {exp_tog, 24'h01010A};
    checks++; if (MOUSE !== exp_m) begin fails++; $display("FAIL midreset_commit: got %h expected %h", MOUSE, exp_m); end
  endtask

  initial begin
    CLK = 1'b0;
    RESET_N = 1'b0;
    CE = 1'b1;
    ENABLE = 1'b1;
    ps2.PS2_VALID = 1'b0;
    ps2.PS2_DATA = 8'h00;
    ps2.PS2_ERR = 1'b0;
    checks = 0;
    fails = 0;
    err_total = 0;
    err_base = 0;
    exp_tog = 1'b0;
    exp_m = 25'd0;
    #1;
    test_reset;
    test_back_to_back;
    test_resync;
    test_overflow;
    test_timeout;
    test_no_timeout;
    test_ce_gate;
    test_ps2_err;
    test_enable;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
